// File: rtl/kfps2kb_rx_controller_if.sv
// Consumer-side scancode buffer port of kfps2kb_rx_controller.
// Handshake: a transfer happens on a rising clock edge when fifo_valid and
// fifo_ready are both 1; fifo_data/fifo_break/fifo_extended stay stable while
// fifo_valid is 1 and fifo_ready is 0; fifo_valid never depends on fifo_ready.
interface kfps2kb_rx_controller_if;
  logic [7:0] fifo_data;
  logic       fifo_break;
  logic       fifo_extended;
  logic       fifo_valid;
  logic       fifo_ready;

  modport master (
    output fifo_data, fifo_break, fifo_extended, fifo_valid,
    input  fifo_ready
  );

  modport slave (
    input  fifo_data, fifo_break, fifo_extended, fifo_valid,
    output fifo_ready
  );
endinterface

// File: rtl/kfps2kb_rx_controller.sv
// PS/2 receive controller: sequences the shift register per frame, runs a
// stall watchdog, inhibits the device clock after errors or when the byte
// buffer is nearly full, and buffers received bytes (first-word-fall-through).
// Optional feature macro: KFPS2KB_RX_CONTROLLER_PREFIX_DECODE_EN folds the
// E0 (extended) and F0 (break) prefixes into flags on the following byte.
module kfps2kb_rx_controller #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000,
  parameter logic [15:0] INHIBIT_CYCLES = 16'd5000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           device_clock,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_received,
  input  logic                           rx_error,
  output logic                           rx_reset,
  output logic                           device_clock_inhibit,
  kfps2kb_rx_controller_if.master        fifo,
  output logic [7:0]                     error_count,
  output logic                           overrun,
  input  logic                           clear_status,
  output logic [2:0]                     state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] HIGH_C  = (PTR_W+1)'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0] LOW_C   = (PTR_W+1)'(FIFO_DEPTH / 2);
`ifdef KFPS2KB_RX_CONTROLLER_PREFIX_DECODE_EN
  localparam int ENTRY_W = 10;  // {break, extended, byte}
`else
  localparam int ENTRY_W = 8;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FRAME   = 3'd1,
    ST_RECOVER = 3'd2,
    ST_INHIBIT = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t               state;
  logic [15:0]          timer;
  logic                 prev_clock;
  logic                 fall;
  logic [PTR_W:0]       wptr, rptr, count, count_next;
  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   push_entry, head;
  logic                 push_req, push_ok, drop, pop, valid, full;
  logic [1:0]           err_inc;
  logic [8:0]           err_sum;

  assign fall      = prev_clock & ~device_clock;
  assign count     = wptr - rptr;
  assign valid     = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = valid & fifo.fifo_ready;
  assign state_dbg = state;

`ifdef KFPS2KB_RX_CONTROLLER_PREFIX_DECODE_EN
  logic pend_break, pend_extended, is_prefix;
  assign is_prefix  = (rx_data == 8'hE0) || (rx_data == 8'hF0);
  assign push_req   = rx_received & ~is_prefix;
  assign push_entry = {pend_break, pend_extended, rx_data};

  // Prefix bytes arm the pending flags; the next real byte consumes them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_break    <= 1'b0;
      pend_extended <= 1'b0;
    end else if (rx_error || state == ST_RECOVER) begin
      pend_break    <= 1'b0;
      pend_extended <= 1'b0;
    end else if (rx_received) begin
      if (rx_data == 8'hE0) begin
        pend_extended <= 1'b1;
      end else if (rx_data == 8'hF0) begin
        pend_break <= 1'b1;
      end else begin
        pend_break    <= 1'b0;
        pend_extended <= 1'b0;
      end
    end
  end

  assign fifo.fifo_break    = valid & head[9];
  assign fifo.fifo_extended = valid & head[8];
`else
  assign push_req           = rx_received;
  assign push_entry         = rx_data;
  assign fifo.fifo_break    = 1'b0;
  assign fifo.fifo_extended = 1'b0;
`endif

  // A full buffer still accepts a byte when the same cycle pops the head.
  assign push_ok    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign count_next = count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

  assign head            = mem[rptr[PTR_W-1:0]];
  assign fifo.fifo_valid = valid;
  assign fifo.fifo_data  = valid ? head[7:0] : 8'h00;

  // Buffer storage; emptiness is defined by the pointers, so no reset here.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr[PTR_W-1:0]] <= push_entry;
  end

  // Buffer pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // Error/stall counter (saturating) and sticky overrun; clear wins.
  assign err_inc = {1'b0, rx_error} + {1'b0, state == ST_RECOVER};
  assign err_sum = {1'b0, error_count} + {7'b0, err_inc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_count <= 8'h00;
      overrun     <= 1'b0;
    end else if (clear_status) begin
      error_count <= 8'h00;
      overrun     <= 1'b0;
    end else begin
      if (err_inc != 2'd0) error_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (drop) overrun <= 1'b1;
    end
  end

  // Frame sequencer with registered rx_reset and inhibit outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= ST_IDLE;
      timer                <= 16'd0;
      prev_clock           <= 1'b0;
      rx_reset             <= 1'b0;
      device_clock_inhibit <= 1'b0;
    end else begin
      prev_clock <= device_clock;
      rx_reset   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_error) begin
            state                <= ST_INHIBIT;
            timer                <= 16'd0;
            device_clock_inhibit <= 1'b1;
          end else if (count >= HIGH_C) begin
            state                <= ST_HOLD;
            device_clock_inhibit <= 1'b1;
          end else if (fall) begin
            state <= ST_FRAME;
            timer <= 16'd0;
          end
        end
        ST_FRAME: begin
          if (rx_error) begin
            state                <= ST_INHIBIT;
            timer                <= 16'd0;
            device_clock_inhibit <= 1'b1;
          end else if (rx_received) begin
            if (count_next >= HIGH_C) begin
              state                <= ST_HOLD;
              device_clock_inhibit <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timer == TIMEOUT_CYCLES - 16'd1) begin
            state    <= ST_RECOVER;
            rx_reset <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RECOVER: begin
          state                <= ST_INHIBIT;
          timer                <= 16'd0;
          device_clock_inhibit <= 1'b1;
        end
        ST_INHIBIT: begin
          if (timer == INHIBIT_CYCLES - 16'd1) begin
            if (count >= HIGH_C) begin
              state <= ST_HOLD;
            end else begin
              state                <= ST_IDLE;
              device_clock_inhibit <= 1'b0;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_HOLD: begin
          if (count <= LOW_C) begin
            state                <= ST_IDLE;
            device_clock_inhibit <= 1'b0;
          end
        end
        default: begin
          state                <= ST_IDLE;
          device_clock_inhibit <= 1'b0;
        end
      endcase
    end
  end

endmodule
